// File: rtl/text_pkg.sv
// Shared cell layout, FSM states and glyph geometry for the text renderer.
package text_pkg;

    localparam int unsigned CELL_W    = 16;
    localparam int unsigned CODE_LSB  = 0;
    localparam int unsigned CODE_W    = 8;
    localparam int unsigned FG_LSB    = 8;
    localparam int unsigned FG_W      = 3;
    localparam int unsigned BG_LSB    = 11;
    localparam int unsigned BG_W      = 3;
    localparam int unsigned BLINK_BIT = 14;
    localparam int unsigned RSVD_BIT  = 15;

    localparam logic [CELL_W-1:0] CLEAR_CELL = 16'h0720;

    localparam int unsigned GLYPH_W = 8;
    localparam int unsigned GLYPH_H = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/char_ram.sv
// Simple dual-port character/attribute RAM with registered read, old data on collision.
module char_ram #(
    parameter int unsigned DEPTH = 600,
    parameter int unsigned AW    = 10,
    parameter int unsigned DW    = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write port and registered read port; no reset so the array maps to block RAM
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/text_renderer.sv
// Text-mode pixel generator: cell RAM lookup, glyph fetch, colour/blink/cursor, clear engine.
module text_renderer #(
    parameter int unsigned COLS         = 40,
    parameter int unsigned ROWS         = 15,
    parameter int unsigned ZOOM_LOG2    = 1,
    parameter int unsigned BLINK_FRAMES = 30,
    parameter int unsigned CELL_AW      = $clog2(COLS*ROWS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [10:0]        x,
    input  logic [10:0]        y,
    input  logic               de,
    input  logic               frame_start,
    output logic [2:0]         o_pixel,
    output logic               o_de,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [CELL_AW-1:0] wr_addr,
    input  logic [15:0]        wr_data,
    input  logic               clr_req,
    output logic               clr_busy,
    input  logic               cursor_en,
    input  logic [7:0]         cursor_col,
    input  logic [5:0]         cursor_row,
    output logic [10:0]        glyph_addr,
    input  logic [7:0]         glyph_q
);

    import text_pkg::*;

    localparam int unsigned CELLS  = COLS * ROWS;
    localparam int unsigned GCOL_W = $clog2(GLYPH_W);
    localparam int unsigned GROW_W = $clog2(GLYPH_H);
    localparam int unsigned BW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    state_t              state_q, state_d;
    logic [CELL_AW-1:0]  idx_q;
    logic                ram_we;
    logic [CELL_AW-1:0]  ram_waddr;
    logic [CELL_W-1:0]   ram_wdata;
    logic [CELL_W-1:0]   rd_data;

    logic [BW-1:0]       blink_cnt;
    logic                blink_phase;

    logic [10:0]         col_c, row_c;
    logic                vis_c, cur_c;
    logic [CELL_AW-1:0]  rd_addr_c;
    logic [GCOL_W-1:0]   gcol_c;
    logic [GROW_W-1:0]   grow_c;

    logic                s1_vis, s1_de, s1_cur;
    logic [GCOL_W-1:0]   s1_gcol;
    logic [GROW_W-1:0]   s1_grow;

    logic                s2_vis, s2_de, s2_cur, s2_blink;
    logic [GCOL_W-1:0]   s2_gcol;
    logic [FG_W-1:0]     s2_fg;
    logic [BG_W-1:0]     s2_bg;

    logic [2:0]          pixel_c;
    logic                unused_bits;

    // Clear-engine state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= CLEAR;
        else        state_q <= state_d;
    end

    // Clear index walks the RAM while clearing and parks at zero otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                idx_q <= '0;
        else if (state_q == CLEAR) idx_q <= idx_q + CELL_AW'(1);
        else                       idx_q <= '0;
    end

    // Next-state: clear request starts a sweep, last address ends it
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (clr_req) state_d = CLEAR;
            CLEAR:   if (32'(idx_q) == CELLS - 1) state_d = IDLE;
            default: state_d = state_q;
        endcase
    end

    // FSM outputs: handshake, busy flag and RAM write port mux
    always_comb begin
        clr_busy  = 1'b0;
        wr_ready  = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = wr_addr;
        ram_wdata = wr_data;
        if (state_q == CLEAR) begin
            clr_busy  = 1'b1;
            ram_we    = 1'b1;
            ram_waddr = idx_q;
            ram_wdata = CLEAR_CELL;
        end else begin
            wr_ready = ~clr_req;
            ram_we   = wr_valid & ~clr_req & (32'(wr_addr) < CELLS);
        end
    end

    // Blink half-period counter driven by frame pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_start) begin
            if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    // Cell coordinates, visibility, cursor match and read address
    always_comb begin
        col_c     = x >> (GCOL_W + ZOOM_LOG2);
        row_c     = y >> (GROW_W + ZOOM_LOG2);
        gcol_c    = GCOL_W'(x >> ZOOM_LOG2);
        grow_c    = GROW_W'(y >> ZOOM_LOG2);
        vis_c     = de && (32'(col_c) < COLS) && (32'(row_c) < ROWS);
        cur_c     = cursor_en && (col_c == 11'(cursor_col)) && (row_c == 11'(cursor_row));
        rd_addr_c = vis_c ? (CELL_AW'(row_c) * CELL_AW'(COLS) + CELL_AW'(col_c)) : '0;
    end

    char_ram #(
        .DEPTH (CELLS),
        .AW    (CELL_AW),
        .DW    (CELL_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (rd_addr_c),
        .rdata (rd_data)
    );

    // Stage 1: carry pixel context alongside the RAM read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vis  <= 1'b0;
            s1_de   <= 1'b0;
            s1_cur  <= 1'b0;
            s1_gcol <= '0;
            s1_grow <= '0;
        end else begin
            s1_vis  <= vis_c;
            s1_de   <= de;
            s1_cur  <= cur_c;
            s1_gcol <= gcol_c;
            s1_grow <= grow_c;
        end
    end

    // Glyph ROM address from the fetched code; code bit 7 and reserved bit are ignored
    assign glyph_addr  = s1_vis ? {rd_data[CODE_LSB +: CODE_W-1], s1_grow} : '0;
    assign unused_bits = rd_data[CODE_LSB + CODE_W - 1] ^ rd_data[RSVD_BIT];

    // Stage 2: latch attributes while the ROM looks up the glyph row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vis   <= 1'b0;
            s2_de    <= 1'b0;
            s2_cur   <= 1'b0;
            s2_blink <= 1'b0;
            s2_gcol  <= '0;
            s2_fg    <= '0;
            s2_bg    <= '0;
        end else begin
            s2_vis   <= s1_vis;
            s2_de    <= s1_de;
            s2_cur   <= s1_cur;
            s2_blink <= rd_data[BLINK_BIT];
            s2_gcol  <= s1_gcol;
            s2_fg    <= rd_data[FG_LSB +: FG_W];
            s2_bg    <= rd_data[BG_LSB +: BG_W];
        end
    end

    // Stage 3 colour: glyph bit select, blink hides the glyph, cursor swaps colours
    always_comb begin
        logic          pix_bit;
        logic [FG_W-1:0] fg;
        logic [BG_W-1:0] bg;
        pix_bit = glyph_q[~s2_gcol];
        fg      = s2_fg;
        bg      = s2_bg;
        if (s2_blink && blink_phase) pix_bit = 1'b0;
        if (s2_cur && blink_phase) begin
            fg = s2_bg;
            bg = s2_fg;
        end
        pixel_c = 3'b000;
        if (s2_vis) pixel_c = pix_bit ? fg : bg;
    end

    // Stage 3 output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_pixel <= 3'b000;
            o_de    <= 1'b0;
        end else begin
            o_pixel <= pixel_c;
            o_de    <= s2_de;
        end
    end

endmodule

// File: tb/tb_text_renderer.sv
// Directed self-checking bench for text_renderer with a behavioural glyph ROM.
module tb_text_renderer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] x = '0;
    logic [10:0] y = '0;
    logic        de = 1'b0;
    logic        frame_start = 1'b0;
    logic [2:0]  o_pixel;
    logic        o_de;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [9:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        clr_req = 1'b0;
    logic        clr_busy;
    logic        cursor_en = 1'b0;
    logic [7:0]  cursor_col = '0;
    logic [5:0]  cursor_row = '0;
    logic [10:0] glyph_addr;
    logic [7:0]  glyph_q = '0;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    text_renderer #(
        .COLS         (40),
        .ROWS         (15),
        .ZOOM_LOG2    (1),
        .BLINK_FRAMES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .x           (x),
        .y           (y),
        .de          (de),
        .frame_start (frame_start),
        .o_pixel     (o_pixel),
        .o_de        (o_de),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .clr_req     (clr_req),
        .clr_busy    (clr_busy),
        .cursor_en   (cursor_en),
        .cursor_col  (cursor_col),
        .cursor_row  (cursor_row),
        .glyph_addr  (glyph_addr),
        .glyph_q     (glyph_q)
    );

    always #5 clk = ~clk;

    // Arbitrary but fixed glyph ROM contents
    function automatic logic [7:0] rom_fn(input logic [10:0] a);
        return {a[3:0], a[10:7]} ^ {a[6:4], a[10:6]} ^ 8'h3C;
    endfunction

    always @(posedge clk) glyph_q <= rom_fn(glyph_addr);

    // Expected pixel colour from glyph address, glyph column and cell attributes
    function automatic logic [2:0] model_pix(input logic [10:0] ga, input int gcol,
                                             input logic [2:0] fg, input logic [2:0] bg,
                                             input logic blink, input logic cur, input logic phase);
        logic [7:0] r;
        logic       b;
        logic [2:0] f;
        logic [2:0] g;
        r = rom_fn(ga);
        b = r[7 - gcol];
        f = fg;
        g = bg;
        if (blink && phase) b = 1'b0;
        if (cur && phase) begin
            f = bg;
            g = fg;
        end
        return b ? f : g;
    endfunction

    task automatic run_pixel(input int px, input int py, input logic pde,
                             output logic [10:0] ga, output logic [2:0] pix, output logic ode);
        @(negedge clk);
        x  = 11'(px);
        y  = 11'(py);
        de = pde;
        @(posedge clk); #1;
        ga = glyph_addr;
        @(posedge clk);
        @(posedge clk); #1;
        pix = o_pixel;
        ode = o_de;
    endtask

    task automatic write_cell(input int addr, input logic [15:0] data, output logic acc);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = 10'(addr);
        wr_data  = data;
        #1 acc = wr_ready;
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic pulse_frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        pulses++;
    endtask

    task automatic test_reset();
        int cnt;
        rst_n = 1'b0;
        de = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (clr_busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", clr_busy); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", wr_ready); end
        checks++; if (o_pixel !== 3'b000) begin errors++; $display("FAIL reset_pixel: got %0d want 0", o_pixel); end
        checks++; if (o_de !== 1'b0) begin errors++; $display("FAIL reset_de: got %b want 0", o_de); end
        checks++; if (glyph_addr !== 11'h000) begin errors++; $display("FAIL reset_gaddr: got %h want 000", glyph_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        de = 1'b0;
        cnt = 0;
        while (clr_busy === 1'b1 && cnt < 2000) begin
            @(posedge clk); #1;
            cnt++;
        end
        checks++; if (cnt != 600) begin errors++; $display("FAIL reset_clear_len: got %0d want 600", cnt); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b want 1", wr_ready); end
    endtask

    task automatic test_clear_readback();
        logic [10:0] ga, ega;
        logic [2:0]  pix, epix;
        logic        ode;
        int          px, py;
        for (int c = 0; c < 600; c++) begin
            px  = (c % 40) * 16 + 2 * (c % 8);
            py  = (c / 40) * 32 + 2 * (c % 16);
            run_pixel(px, py, 1'b1, ga, pix, ode);
            ega  = {7'h20, 4'(c % 16)};
            epix = model_pix(ega, c % 8, 3'd7, 3'd0, 1'b0, 1'b0, 1'b0);
            checks++; if (ga !== ega) begin errors++; $display("FAIL clear_gaddr[%0d]: got %h want %h", c, ga, ega); end
            checks++; if (pix !== epix || ode !== 1'b1) begin errors++; $display("FAIL clear_pixel[%0d]: got %0d/%b want %0d/1", c, pix, ode, epix); end
        end
    endtask

    task automatic test_write_glyph();
        logic [10:0] ga, ega;
        logic [2:0]  pix, epix;
        logic        ode, acc;
        write_cell(0, 16'h0241, acc);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL glyph_wr_ready: got %b want 1", acc); end
        for (int yy = 0; yy < 32; yy++) begin
            for (int xx = 0; xx < 16; xx++) begin
                run_pixel(xx, yy, 1'b1, ga, pix, ode);
                ega  = {7'h41, 4'(yy >> 1)};
                epix = model_pix(ega, (xx >> 1) % 8, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0);
                checks++; if (ga !== ega) begin errors++; $display("FAIL glyph_gaddr(%0d,%0d): got %h want %h", xx, yy, ga, ega); end
                checks++; if (pix !== epix) begin errors++; $display("FAIL glyph_pixel(%0d,%0d): got %0d want %0d", xx, yy, pix, epix); end
            end
        end
    endtask

    task automatic test_visibility();
        logic [10:0] ga, ega;
        logic [2:0]  pix, epix;
        logic        ode;
        logic [11:0] pat;
        run_pixel(640, 0, 1'b1, ga, pix, ode);
        checks++; if (pix !== 3'b000 || ode !== 1'b1) begin errors++; $display("FAIL vis_col40: got %0d/%b want 0/1", pix, ode); end
        run_pixel(0, 480, 1'b1, ga, pix, ode);
        checks++; if (pix !== 3'b000 || ode !== 1'b1) begin errors++; $display("FAIL vis_row15: got %0d/%b want 0/1", pix, ode); end
        run_pixel(0, 0, 1'b0, ga, pix, ode);
        checks++; if (pix !== 3'b000 || ode !== 1'b0) begin errors++; $display("FAIL vis_de0: got %0d/%b want 0/0", pix, ode); end
        run_pixel(639, 479, 1'b1, ga, pix, ode);
        ega  = {7'h20, 4'd15};
        epix = model_pix(ega, 7, 3'd7, 3'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (ga !== ega) begin errors++; $display("FAIL vis_last_gaddr: got %h want %h", ga, ega); end
        checks++; if (pix !== epix || ode !== 1'b1) begin errors++; $display("FAIL vis_last_pixel: got %0d/%b want %0d/1", pix, ode, epix); end
        pat = 12'b1011_0010_1101;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            x  = '0;
            y  = '0;
            de = pat[i];
            @(posedge clk); #1;
            if (i >= 2) begin
                checks++; if (o_de !== pat[i-2]) begin errors++; $display("FAIL de_delay[%0d]: got %b want %b", i, o_de, pat[i-2]); end
            end
        end
        de = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [10:0] ga0, ga1;
        logic        acc;
        @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = 10'd2;
        wr_data  = 16'h0443;
        x  = 11'd32;
        y  = 11'd0;
        de = 1'b1;
        #1 acc = wr_ready;
        @(posedge clk); #1;
        ga0 = glyph_addr;
        wr_valid = 1'b0;
        @(posedge clk); #1;
        ga1 = glyph_addr;
        de = 1'b0;
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", acc); end
        checks++; if (ga0 !== {7'h20, 4'd0}) begin errors++; $display("FAIL b2b_old_data: got %h want 200", ga0); end
        checks++; if (ga1 !== {7'h43, 4'd0}) begin errors++; $display("FAIL b2b_new_data: got %h want 430", ga1); end
    endtask

    task automatic test_blink_cursor();
        logic [10:0] ga, ega;
        logic [2:0]  pix, epix;
        logic        ode, acc, phase;
        write_cell(5, 16'h6342, acc);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL blink_wr_ready: got %b want 1", acc); end
        cursor_col = 8'd5;
        cursor_row = 6'd0;
        for (int f = 0; f < 8; f++) begin
            cursor_en = (f >= 4);
            phase = ((pulses / 2) % 2) == 1;
            for (int g = 0; g < 8; g++) begin
                run_pixel(80 + 2 * g, 6, 1'b1, ga, pix, ode);
                ega  = {7'h42, 4'd3};
                epix = model_pix(ega, g, 3'd3, 3'd4, 1'b1, cursor_en, phase);
                checks++; if (pix !== epix) begin errors++; $display("FAIL blink_f%0d_g%0d: got %0d want %0d", f, g, pix, epix); end
            end
            pulse_frame();
        end
        cursor_col = 8'd0;
        cursor_en  = 1'b1;
        for (int f = 0; f < 4; f++) begin
            phase = ((pulses / 2) % 2) == 1;
            for (int g = 0; g < 8; g++) begin
                run_pixel(2 * g, 6, 1'b1, ga, pix, ode);
                ega  = {7'h41, 4'd3};
                epix = model_pix(ega, g, 3'd2, 3'd0, 1'b0, 1'b1, phase);
                checks++; if (pix !== epix) begin errors++; $display("FAIL cursor_f%0d_g%0d: got %0d want %0d", f, g, pix, epix); end
            end
            pulse_frame();
        end
        cursor_en = 1'b0;
    endtask

    task automatic test_clear_collision();
        logic [10:0] ga;
        logic [2:0]  pix;
        logic        ode, acc;
        int          cnt;
        @(negedge clk);
        clr_req  = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = 10'd3;
        wr_data  = 16'h0155;
        #1 acc = wr_ready;
        checks++; if (acc !== 1'b0) begin errors++; $display("FAIL coll_ready: got %b want 0", acc); end
        @(posedge clk); #1;
        clr_req  = 1'b0;
        wr_valid = 1'b0;
        checks++; if (clr_busy !== 1'b1) begin errors++; $display("FAIL coll_busy: got %b want 1", clr_busy); end
        cnt = 0;
        while (clr_busy === 1'b1 && cnt < 2000) begin
            clr_req = (cnt == 300);
            @(posedge clk); #1;
            cnt++;
        end
        clr_req = 1'b0;
        checks++; if (cnt != 600) begin errors++; $display("FAIL coll_clear_len: got %0d want 600", cnt); end
        write_cell(600, 16'h0155, acc);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL oob_ready: got %b want 1", acc); end
        run_pixel(0, 0, 1'b1, ga, pix, ode);
        checks++; if (ga !== {7'h20, 4'd0}) begin errors++; $display("FAIL oob_cell0: got %h want 200", ga); end
        run_pixel(639, 479, 1'b1, ga, pix, ode);
        checks++; if (ga !== {7'h20, 4'd15}) begin errors++; $display("FAIL oob_cell599: got %h want 20f", ga); end
        run_pixel(48, 0, 1'b1, ga, pix, ode);
        checks++; if (ga !== {7'h20, 4'd0}) begin errors++; $display("FAIL coll_cell3: got %h want 200", ga); end
        de = 1'b0;
    endtask

    task automatic test_reset_mid_clear();
        int cnt;
        @(negedge clk);
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (clr_busy !== 1'b1 || wr_ready !== 1'b0) begin errors++; $display("FAIL midrst_state: got busy %b ready %b want 1/0", clr_busy, wr_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        while (clr_busy === 1'b1 && cnt < 2000) begin
            @(posedge clk); #1;
            cnt++;
        end
        checks++; if (cnt != 600) begin errors++; $display("FAIL midrst_clear_len: got %0d want 600", cnt); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", wr_ready); end
    endtask

    initial begin
        test_reset();
        test_clear_readback();
        test_write_glyph();
        test_visibility();
        test_back_to_back();
        test_blink_cursor();
        test_clear_collision();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
